// File: rtl/wait2_sched.sv
// wait2_sched: round-robin scheduler that shares a single WAIT/WAIT0 wait element
// among N requesters through a four-phase ctrl/san handshake.
//
// Ports:
//   clk   - rising-edge clock, single domain
//   rst   - synchronous active-high reset
//   req   - per-requester wait request (level, held until that requester's done)
//   lvl   - per-requester target level for the wait element (stable while req high)
//   gnt   - one-hot grant, zero when idle
//   done  - one-cycle completion pulse for the granted requester
//   err   - qualifies done: 1 when the handshake timed out
//   sel   - level select to the wait element
//   ctrl  - four-phase request to the wait element
//   san   - asynchronous acknowledge from the wait element
module wait2_sched #(
  parameter int unsigned N       = 4,
  parameter int unsigned TMO_W   = 16,
  parameter int unsigned TMO_CYC = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] lvl,
  output logic [N-1:0] gnt,
  output logic         done,
  output logic         err,
  output logic         sel,
  output logic         ctrl,
  input  logic         san
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_REL   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             sel_q, sel_d;
  logic [PW-1:0]    win_q, win_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             err_flag_q, err_flag_d;
  logic             san_m_q, san_m_d;
  logic             san_s_q, san_s_d;
  logic [1:0]       vld_q, vld_d;

  logic             found;
  logic [PW-1:0]    win_idx;
  logic             san_idle_ok;

  // Round-robin pick: first set req bit at or after ptr, wrapping modulo N.
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] idx_l;
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx   = (int'(ptr_q) + k) % N;
      idx_l = PW'(idx);
      if (!found && req[idx_l]) begin
        found   = 1'b1;
        win_idx = idx_l;
      end
    end
  end

  // vld tracks how many synchronizer stages hold real samples since reset.
  // Reset zeroes san_s, so a 0 there only means "released" once the pipeline
  // has refilled; this keeps a reset mid-handshake from starting a new one
  // while the wait element is still acknowledging the old one.
  assign san_idle_ok = vld_q[1] && !san_s_q;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    win_d      = win_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;
    san_m_d    = san;
    san_s_d    = san_m_q;
    vld_d      = {vld_q[0], 1'b1};

    case (state_q)
      S_IDLE: begin
        if (found && san_idle_ok) begin
          state_d    = S_SETUP;
          gnt_d      = '0;
          gnt_d[win_idx] = 1'b1;
          sel_d      = lvl[win_idx];
          win_d      = win_idx;
          err_flag_d = 1'b0;
        end
      end
      S_SETUP: begin
        state_d = S_REQ;
        cnt_d   = '0;
      end
      S_REQ: begin
        if (san_s_q) begin
          state_d = S_REL;
        end else if (cnt_q == TMO_W'(TMO_CYC - 1)) begin
          state_d    = S_REL;
          err_flag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REL: begin
        if (!san_s_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        sel_d   = 1'b0;
        ptr_d   = (win_q == PW'(N - 1)) ? '0 : win_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        sel_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      sel_q      <= 1'b0;
      win_q      <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      san_m_q    <= 1'b0;
      san_s_q    <= 1'b0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      win_q      <= win_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      san_m_q    <= san_m_d;
      san_s_q    <= san_s_d;
      vld_q      <= vld_d;
    end
  end

  // ctrl/done decode straight from state so reset drops ctrl on the same edge.
  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign ctrl = (state_q == S_REQ);
  assign done = (state_q == S_DONE);
  assign err  = (state_q == S_DONE) && err_flag_q;

endmodule

// File: tb/tb_wait2_sched.sv
// tb_wait2_sched: directed bench for wait2_sched (N=4, TMO_CYC=10) with a
// wait-element model that echoes ctrl after 3 cycles, or holds san at 0 or 1.
module tb_wait2_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] lvl;
  logic [3:0] gnt;
  logic       done;
  logic       err;
  logic       sel;
  logic       ctrl;
  logic       san;

  int unsigned san_mode = 0;  // 0 = echo ctrl delayed, 1 = hold 0, 2 = hold 1
  logic [2:0]  dly = '0;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned ctrl_hi = 0;
  int unsigned ctrl_rise = 0;
  int unsigned done_cnt = 0;
  int unsigned done_seen = 0;
  logic        ctrl_prev = 1'b0;

  typedef struct packed {
    logic [3:0] gnt;
    logic       sel;
    logic       err;
  } exp_t;

  exp_t q[$];

  wait2_sched #(.N(4), .TMO_W(16), .TMO_CYC(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .lvl  (lvl),
    .gnt  (gnt),
    .done (done),
    .err  (err),
    .sel  (sel),
    .ctrl (ctrl),
    .san  (san)
  );

  always #5 clk = ~clk;

  always @(negedge clk) dly <= {dly[1:0], ctrl};

  assign san = (san_mode == 0) ? dly[2] : (san_mode == 2);

  always @(negedge clk) begin
    if (ctrl) ctrl_hi <= ctrl_hi + 1;
    if (ctrl && !ctrl_prev) ctrl_rise <= ctrl_rise + 1;
    ctrl_prev <= ctrl;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Waits up to bound negedges for done, then pops and compares the scoreboard.
  task automatic wait_done(input string tag, input int unsigned bound);
    bit   seen = 1'b0;
    exp_t e;
    for (int unsigned i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      done_seen++;
      chk({tag, "_sb_nonempty"}, 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({tag, "_gnt"}, 32'(gnt), 32'(e.gnt));
        chk({tag, "_sel"}, 32'(sel), 32'(e.sel));
        chk({tag, "_err"}, 32'(err), 32'(e.err));
      end
    end
  endtask

  task automatic wait_ctrl(input string tag, input int unsigned bound);
    for (int unsigned i = 0; i < bound && !ctrl; i++) @(negedge clk);
    chk({tag, "_ctrl_up"}, 32'(ctrl), 32'd1);
  endtask

  initial begin
    int unsigned base;
    rst = 1'b1;
    req = '0;
    lvl = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);

    // Single request, echoing wait element.
    rst = 1'b0;
    req = 4'b0001;
    lvl = 4'b0001;
    q.push_back('{gnt: 4'b0001, sel: 1'b1, err: 1'b0});
    base = ctrl_rise;
    for (int unsigned i = 0; i < 20 && gnt == 4'b0000; i++) @(negedge clk);
    chk("t1_setup_gnt", 32'(gnt), 32'h1);
    chk("t1_setup_sel", 32'(sel), 32'h1);
    chk("t1_setup_ctrl", 32'(ctrl), 32'h0);
    @(negedge clk);
    chk("t1_req_ctrl", 32'(ctrl), 32'h1);
    wait_done("t1", 40);
    req = '0;
    chk("t1_ctrl_pulses", ctrl_rise - base, 32'd1);
    @(negedge clk);
    chk("t1_idle_gnt", 32'(gnt), 32'h0);

    // All four requesting: strict rotation from pointer 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    lvl = 4'b1010;
    for (int unsigned k = 0; k < 8; k++)
      q.push_back('{gnt: 4'(1 << (k % 4)), sel: lvl[k % 4], err: 1'b0});
    for (int unsigned k = 0; k < 8; k++) wait_done("t2_rr", 40);
    req = '0;

    // Timeout: san held low, requester 2.
    san_mode = 1;
    req = 4'b0100;
    lvl = 4'b0100;
    q.push_back('{gnt: 4'b0100, sel: 1'b1, err: 1'b1});
    base = ctrl_hi;
    wait_done("t3_tmo", 60);
    req = '0;
    chk("t3_ctrl_cycles", ctrl_hi - base, 32'd10);
    san_mode = 0;
    // Pointer now at 3: with everyone requesting, requester 3 wins.
    req = 4'b1111;
    lvl = 4'b0000;
    q.push_back('{gnt: 4'b1000, sel: 1'b0, err: 1'b0});
    wait_done("t3_ptr", 40);
    req = '0;

    // san stuck high after ack: parked in REL until released.
    req = 4'b0001;
    q.push_back('{gnt: 4'b0001, sel: 1'b0, err: 1'b0});
    wait_ctrl("t4", 20);
    san_mode = 2;
    base = done_cnt;
    repeat (10) @(negedge clk);
    chk("t4_rel_ctrl", 32'(ctrl), 32'd0);
    chk("t4_rel_no_done", done_cnt - base, 32'd0);
    chk("t4_rel_gnt", 32'(gnt), 32'h1);
    san_mode = 0;
    @(negedge clk);
    chk("t4_rel_done_1", 32'(done), 32'd0);
    @(negedge clk);
    chk("t4_rel_done_2", 32'(done), 32'd0);
    wait_done("t4_release", 1);
    req = '0;

    // Reset mid-handshake while san high; no restart until san falls.
    req = 4'b0010;
    wait_ctrl("t5", 20);
    san_mode = 2;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_ctrl_drop", 32'(ctrl), 32'd0);
    chk("t5_gnt_drop", 32'(gnt), 32'd0);
    rst = 1'b0;
    base = ctrl_rise;
    repeat (8) @(negedge clk);
    chk("t5_no_new_ctrl", ctrl_rise - base, 32'd0);
    chk("t5_hold_gnt", 32'(gnt), 32'd0);
    san_mode = 0;
    q.push_back('{gnt: 4'b0010, sel: 1'b0, err: 1'b0});
    wait_done("t5_serve", 40);
    req = '0;

    // Granted requester drops req mid-handshake; next one still served.
    req = 4'b0101;
    lvl = 4'b0001;
    q.push_back('{gnt: 4'b0100, sel: 1'b0, err: 1'b0});
    q.push_back('{gnt: 4'b0001, sel: 1'b1, err: 1'b0});
    wait_ctrl("t6", 20);
    chk("t6_gnt_in_req", 32'(gnt), 32'h4);
    req = 4'b0001;
    wait_done("t6_dropped", 40);
    wait_done("t6_next", 40);
    req = '0;
    @(negedge clk);
    chk("t6_idle_gnt", 32'(gnt), 32'h0);

    repeat (3) @(negedge clk);
    chk("end_done_count", done_cnt, done_seen);
    chk("end_sb_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
